spifs_xip_seq: RTL

//  Memory-mapped XIP read sequencer upstream of the spifs SPI master core.
//  - Accepts 32-bit word reads in 0x4000_0000..0x407F_FFFF.
//  - Drives the core's register port (DIV, TXD1, TXD0, CTL) to run one 64-bit
//    0x03 READ transfer, waits for the core irq, then reads RXD0.
//  - Returns the read word to the bus side. Holds a 1-word last-read cache.

---
 rtl/spifs_xip_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spifs_xip_seq.sv
// XIP read sequencer: turns bus word reads into spifs 0x03 READ transfers.
// Keeps a single-word cache of the last successful flash read.
module spifs_xip_seq #(
  parameter logic [7:0]  CLK_DIV  = 8'd1,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        xip_req_i,
  input  logic [31:0] xip_addr_i,
  output logic        xip_gnt_o,
  output logic        xip_rvalid_o,
  input  logic        xip_rready_i,
  output logic [31:0] xip_rdata_o,
  output logic        xip_err_o,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_wdata_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_ack_i,
  input  logic        irq_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CSR, S_TXD0, S_TXD1,
    S_CTL, S_WAIT, S_RXD0, S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_live;
  logic        r_csr_done;
  logic [20:0] r_faddr;
  logic [15:0] r_cnt;
  logic        r_c_valid;
  logic [20:0] r_c_tag;
  logic [31:0] r_c_data;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_hs;
  logic w_inrange;
  logic w_hit;
  logic w_tmo;
  logic w_unused;

  assign w_hs      = xip_req_i & xip_gnt_o;
  assign w_inrange = (xip_addr_i[31:23] == 9'h080);
  assign w_hit     = CACHE_EN & r_c_valid &
                     (r_c_tag == xip_addr_i[22:2]);
  assign w_tmo     = (r_cnt == TIMEOUT);
  assign w_unused  = ^xip_addr_i[1:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          if (!w_inrange || w_hit) w_next = S_RESP;
          else if (!r_csr_done)    w_next = S_CSR;
          else                     w_next = S_TXD0;
        end
      end
      S_CSR:  if (reg_ack_i) w_next = S_TXD0;
      S_TXD0: if (reg_ack_i) w_next = S_TXD1;
      S_TXD1: if (reg_ack_i) w_next = S_CTL;
      S_CTL:  if (reg_ack_i) w_next = S_WAIT;
      S_WAIT: begin
        if (irq_i)      w_next = S_RXD0;
        else if (w_tmo) w_next = S_RESP;
      end
      S_RXD0: if (reg_ack_i) w_next = S_RESP;
      S_RESP: if (xip_rready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_live keeps gnt low while reset is held
  always_comb begin
    xip_gnt_o    = 1'b0;
    xip_rvalid_o = 1'b0;
    xip_rdata_o  = 32'h0;
    xip_err_o    = 1'b0;
    reg_wr_o     = 1'b0;
    reg_rd_o     = 1'b0;
    reg_addr_o   = 5'h00;
    reg_wdata_o  = 32'h0;
    unique case (r_state)
      S_IDLE: xip_gnt_o = r_live;
      S_CSR: begin
        reg_wr_o    = 1'b1;
        reg_addr_o  = 5'h14;
        reg_wdata_o = {24'h0, CLK_DIV};
      end
      S_TXD0: begin
        reg_wr_o    = 1'b1;
        reg_addr_o  = 5'h00;
      end
      S_TXD1: begin
        reg_wr_o    = 1'b1;
        reg_addr_o  = 5'h04;
        reg_wdata_o = {8'h03, 1'b0, r_faddr, 2'b00};
      end
      S_CTL: begin
        reg_wr_o    = 1'b1;
        reg_addr_o  = 5'h10;
        reg_wdata_o = 32'h0100_7540;
      end
      S_RXD0: begin
        reg_rd_o    = 1'b1;
        reg_addr_o  = 5'h00;
      end
      S_RESP: begin
        xip_rvalid_o = 1'b1;
        xip_rdata_o  = r_rdata;
        xip_err_o    = r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_live     <= 1'b0;
      r_csr_done <= 1'b0;
      r_faddr    <= '0;
      r_cnt      <= '0;
      r_c_valid  <= 1'b0;
      r_c_tag    <= '0;
      r_c_data   <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_cnt  <= (r_state == S_WAIT) ? r_cnt + 16'd1 : 16'd0;
      if (r_state == S_IDLE && w_hs) begin
        if (!w_inrange) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else if (w_hit) begin
          r_rdata <= r_c_data;
          r_err   <= 1'b0;
        end else begin
          r_faddr <= xip_addr_i[22:2];
        end
      end
      if (r_state == S_CSR && reg_ack_i)
        r_csr_done <= 1'b1;
      // timeout drops the cache: flash state is unknown
      if (r_state == S_WAIT && !irq_i && w_tmo) begin
        r_rdata   <= '0;
        r_err     <= 1'b1;
        r_c_valid <= 1'b0;
      end
      if (r_state == S_RXD0 && reg_ack_i) begin
        r_rdata   <= reg_rdata_i;
        r_err     <= 1'b0;
        r_c_tag   <= r_faddr;
        r_c_data  <= reg_rdata_i;
        r_c_valid <= CACHE_EN;
      end
    end
  end

endmodule
